freqmeter_channel: RTL



---
 rtl/freqmeter_channel.sv | 115 +++++++++++
 1 files changed

// File: rtl/freqmeter_channel.sv
// freqmeter_channel: reciprocal measurement of N input periods against a master timestamp.
// Optional dead-input abort enabled by defining FREQMETER_CH_TIMEOUT_EN.
module freqmeter_channel #(
  parameter int CNT_WIDTH      = 24,
  parameter int TS_WIDTH       = 30,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 f_in,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] periods_i,
  input  logic [TS_WIDTH-1:0]  timestamp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] res_periods_o,
  output logic [TS_WIDTH-1:0]  res_ticks_o
);
  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;
  state_t state_q;
  logic s1_q, s2_q, s3_q;
  logic busy_q, done_q, timeout_q;
  logic [CNT_WIDTH-1:0] n_q, cnt_q, res_periods_q, cnt_inc;
  logic [TS_WIDTH-1:0] ts_start_q, ts_last_q, res_ticks_q;
  logic rise, to_hit;
  assign rise    = s2_q & ~s3_q;
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
`ifdef FREQMETER_CH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic active;
  assign active = (state_q == ARM) || (state_q == COUNT);
  assign to_hit = active && !rise && (to_q == TW'(TIMEOUT_CYCLES - 1));
  // cleared while idle so ARM entry always starts from zero
  always_ff @(posedge clk_i) begin
    if (rst_i || !active || rise) to_q <= '0;
    else to_q <= to_q + TW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      {s1_q, s2_q, s3_q} <= '0;
      {busy_q, done_q, timeout_q} <= '0;
      n_q           <= '0;
      cnt_q         <= '0;
      ts_start_q    <= '0;
      ts_last_q     <= '0;
      res_periods_q <= '0;
      res_ticks_q   <= '0;
    end else begin
      s1_q   <= f_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (!stop_i && start_i && periods_i != '0) begin
          n_q     <= periods_i;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ARM;
        end
        ARM: if (stop_i) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else if (rise) begin
          ts_start_q <= timestamp_i;
          ts_last_q  <= timestamp_i;
          cnt_q      <= '0;
          state_q    <= COUNT;
        end else if (to_hit) begin
          res_periods_q <= cnt_q;
          res_ticks_q   <= '0;
          timeout_q     <= 1'b1;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= DONE;
        end
        COUNT: if (stop_i) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else if (rise) begin
          cnt_q     <= cnt_inc;
          ts_last_q <= timestamp_i;
          if (cnt_inc == n_q) begin
            res_periods_q <= n_q;
            res_ticks_q   <= timestamp_i - ts_start_q;
            timeout_q     <= 1'b0;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= DONE;
          end
        end else if (to_hit) begin
          res_periods_q <= cnt_q;
          res_ticks_q   <= ts_last_q - ts_start_q;
          timeout_q     <= 1'b1;
          done_q        <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign res_periods_o = res_periods_q;
  assign res_ticks_o   = res_ticks_q;
endmodule
